univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
- Parametrised successor to the single-bit master-slave D flip-flop: a WIDTH-bit universal register built on the same edge-triggered storage.
- Supports hold, shift-left, shift-right and parallel-load modes.
- Provides true and complemented outputs, plus a saturating shift counter with a full-word-shifted flag.
- Used as the serial/parallel conversion stage in assignment datapaths.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
- CNT_W, $clog2(WIDTH+1), shift counter width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- res  input  1  reset, asynchronous, active-low.
- mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sr_in  input  1  serial input entering at MSB on shift right.
- sl_in  input  1  serial input entering at LSB on shift left.
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- qn  output  WIDTH  bitwise complement of q.
- so_r  output  1  bit shifted out on shift right; equals q[0].
- so_l  output  1  bit shifted out on shift left; equals q[WIDTH-1].
- shift_cnt  output  CNT_W  number of shifts since last load or reset, saturating.
- word_done  output  1  high when shift_cnt == WIDTH.

Behaviour:
- Reset (res=0), asynchronous and immediate, independent of clk:
  - q = RESET_VAL, qn = ~RESET_VAL, shift_cnt = 0, word_done = 0.
  - Holds for as long as res is low; clk edges are ignored.
  - Reset asserted mid-shift discards contents and count.
- First rising clk edge after res goes high operates normally; there is no extra sync cycle inside the block.
- Per rising clk edge with res=1:
  - mode 00: q and shift_cnt unchanged.
  - mode 01: q <= {sr_in, q[WIDTH-1:1]}; shift_cnt increments.
  - mode 10: q <= {q[WIDTH-2:0], sl_in}; shift_cnt increments.
  - mode 11: q <= d; shift_cnt <= 0.
- shift_cnt saturates at WIDTH; further shifts keep it at WIDTH. Mixed left/right shifts both count.
- Outputs:
  - qn, so_r, so_l and word_done are combinational from registered state only. There is no path from mode, d or the serial inputs to any output.
  - All registered outputs have 1-cycle latency from the sampling edge.
  - qn == ~q holds at all times, including during reset.
- mode and data inputs are sampled only at the rising edge; glitches between edges have no effect.
- X or Z on mode at an edge is not supported; the bench must never drive it.

Optional Feature:
- Macro: USR_ROTATE_EN.
- Defined:
  - Shift modes rotate: mode 01 gives q <= {q[0], q[WIDTH-1:1]}; mode 10 gives q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - sr_in and sl_in are ignored; shift_cnt behaviour is unchanged.
  - After WIDTH rotations q equals its post-load value and word_done=1.
- Not defined: serial inputs are used exactly as in Behaviour; there is no rotate capability.

Test Plan:
- Reset: WIDTH=8, hold res=0 while toggling clk with mode=11, d=8'hFF -> q=8'h00, qn=8'hFF, shift_cnt=0, word_done=0 throughout.
- Parallel load, then right shift: load d=8'hA5, then 8 cycles mode=01 with sr_in=1 -> after cycle 1 q=8'hD2, so_r=0; after cycle 8 q=8'hFF, shift_cnt=8, word_done=1.
- Left shift with saturation: load 8'h01, then 10 cycles mode=10 with sl_in=0 -> q=8'h00 after cycle 8; shift_cnt stays 8 on cycles 9-10; word_done stays high.
- Hold: load 8'h3C, then 5 cycles mode=00 with serial inputs toggling -> q=8'h3C, shift_cnt=0 throughout.
- Asynchronous reset mid-operation: load 8'h5A, 3 right shifts, pulse res low between clk edges -> q=8'h00 and shift_cnt=0 before the next edge; the next mode=11 load of 8'h81 gives q=8'h81.
- USR_ROTATE_EN defined: load 8'h81, mode=01 with sr_in=0 -> q=8'hC0, then 8'h60; after 8 rotations q=8'h81 and word_done=1.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Purpose: WIDTH-bit universal register with hold, shift-right, shift-left and parallel load, plus a saturating shift counter.
// Latency: q/shift_cnt update 1 cycle after the sampling edge; qn, so_r, so_l and word_done are decoded from registered state only.
// Backpressure: none; an operation is accepted on every rising edge while res is high. USR_ROTATE_EN turns the shifts into rotates.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             res,
    input  logic [1:0]       mode,
    input  logic             sr_in,
    input  logic             sl_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             so_r,
    output logic             so_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             word_done
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    // Count value meaning "a whole word has passed through"; it is also the saturation point.
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             shifting;
    logic             fill_r;
    logic             fill_l;

`ifdef USR_ROTATE_EN
    // Rotate mode recirculates the bit leaving the opposite end; the serial inputs are not consumed.
    logic unused_serial;
    assign unused_serial = sr_in ^ sl_in;
    assign fill_r        = q[0];
    assign fill_l        = q[WIDTH-1];
`else
    assign fill_r        = sr_in;
    assign fill_l        = sl_in;
`endif

    // Next register contents and whether this edge counts as a shift.
    always_comb begin
        q_nxt    = q;
        shifting = 1'b0;
        case (mode)
            MODE_HOLD: begin
                q_nxt    = q;
                shifting = 1'b0;
            end
            MODE_SHR: begin
                q_nxt    = {fill_r, q[WIDTH-1:1]};
                shifting = 1'b1;
            end
            MODE_SHL: begin
                q_nxt    = {q[WIDTH-2:0], fill_l};
                shifting = 1'b1;
            end
            MODE_LOAD: begin
                q_nxt    = d;
                shifting = 1'b0;
            end
            default: begin
                q_nxt    = q;
                shifting = 1'b0;
            end
        endcase
    end

    // Shift counter: cleared by a load, incremented by either shift direction, saturating at WIDTH.
    always_comb begin
        cnt_nxt = shift_cnt;
        if (mode == MODE_LOAD) begin
            cnt_nxt = '0;
        end else if (shifting && (shift_cnt != CNT_FULL)) begin
            cnt_nxt = shift_cnt + 1'b1;
        end
    end

    // State register; the asynchronous reset discards both contents and count immediately.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            q         <= RESET_VAL;
            shift_cnt <= '0;
        end else begin
            q         <= q_nxt;
            shift_cnt <= cnt_nxt;
        end
    end

    // Derived outputs come only from registered state, so no input reaches an output combinationally.
    assign qn        = ~q;
    assign so_r      = q[0];
    assign so_l      = q[WIDTH-1];
    assign word_done = (shift_cnt == CNT_FULL);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Purpose: self-checking bench for univ_shift_reg (WIDTH=8) using a reference model and an expected-result queue.
// Latency: expectations are pushed when inputs are driven and popped one edge later, sampled 1 time unit after the edge.
// Backpressure: not applicable; the bench drives one operation per clock.
module tb_univ_shift_reg;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [3:0]   cnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         res;
    logic [1:0]   mode;
    logic         sr_in;
    logic         sl_in;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] qn;
    logic         so_r;
    logic         so_l;
    logic [3:0]   shift_cnt;
    logic         word_done;

    int checks = 0;
    int errors = 0;

    // Reference model state and scoreboard.
    logic [W-1:0] m_q;
    logic [3:0]   m_cnt;
    exp_t         sb[$];
    exp_t         e;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .res       (res),
        .mode      (mode),
        .sr_in     (sr_in),
        .sl_in     (sl_in),
        .d         (d),
        .q         (q),
        .qn        (qn),
        .so_r      (so_r),
        .so_l      (so_l),
        .shift_cnt (shift_cnt),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    // Drive one operation at the falling edge, predict its result, and return 1 unit after the rising edge.
    task automatic step(input logic [1:0] md, input logic sr, input logic sl, input logic [W-1:0] dd);
        exp_t x;
        @(negedge clk);
        mode  = md;
        sr_in = sr;
        sl_in = sl;
        d     = dd;
        case (md)
            2'b01: begin
`ifdef USR_ROTATE_EN
                m_q = {m_q[0], m_q[W-1:1]};
`else
                m_q = {sr, m_q[W-1:1]};
`endif
                if (m_cnt < 4'd8) m_cnt = m_cnt + 4'd1;
            end
            2'b10: begin
`ifdef USR_ROTATE_EN
                m_q = {m_q[W-2:0], m_q[W-1]};
`else
                m_q = {m_q[W-2:0], sl};
`endif
                if (m_cnt < 4'd8) m_cnt = m_cnt + 4'd1;
            end
            2'b11: begin
                m_q   = dd;
                m_cnt = 4'd0;
            end
            default: ;
        endcase
        x.q   = m_q;
        x.cnt = m_cnt;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res   = 1'b0;
        mode  = 2'b11;
        d     = 8'hFF;
        sr_in = 1'b1;
        sl_in = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (q !== 8'h00 || qn !== 8'hFF || shift_cnt !== 4'd0 || word_done !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: q=%h qn=%h cnt=%0d wd=%b, expected q=00 qn=ff cnt=0 wd=0",
                         i, q, qn, shift_cnt, word_done);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        res   = 1'b1;
        m_q   = 8'h00;
        m_cnt = 4'd0;
        sb.delete();
    endtask

    task automatic test_load_shift_right();
        step(2'b11, 1'b0, 1'b0, 8'hA5);
        e = sb.pop_front();
        checks++;
        if (q !== e.q || qn !== ~e.q || shift_cnt !== e.cnt) begin
            errors++;
            $display("FAIL load_a5: q=%h qn=%h cnt=%0d, expected q=%h cnt=%0d", q, qn, shift_cnt, e.q, e.cnt);
        end
        for (int i = 0; i < 8; i++) begin
            step(2'b01, 1'b1, 1'b0, 8'h00);
            e = sb.pop_front();
            checks++;
            if (q !== e.q || qn !== ~e.q || shift_cnt !== e.cnt || word_done !== (e.cnt == 4'd8) ||
                so_r !== e.q[0] || so_l !== e.q[W-1]) begin
                errors++;
                $display("FAIL shr[%0d]: q=%h qn=%h cnt=%0d wd=%b so_r=%b so_l=%b, expected q=%h cnt=%0d",
                         i, q, qn, shift_cnt, word_done, so_r, so_l, e.q, e.cnt);
            end
            if (i == 0) begin
                checks++;
                if (q !== 8'hD2 || so_r !== 1'b0) begin
                    errors++;
                    $display("FAIL shr_first: q=%h so_r=%b, expected q=d2 so_r=0", q, so_r);
                end
            end
        end
        checks++;
`ifdef USR_ROTATE_EN
        if (q !== 8'hA5 || shift_cnt !== 4'd8 || word_done !== 1'b1) begin
            errors++;
            $display("FAIL shr_final: q=%h cnt=%0d wd=%b, expected q=a5 cnt=8 wd=1", q, shift_cnt, word_done);
        end
`else
        if (q !== 8'hFF || shift_cnt !== 4'd8 || word_done !== 1'b1) begin
            errors++;
            $display("FAIL shr_final: q=%h cnt=%0d wd=%b, expected q=ff cnt=8 wd=1", q, shift_cnt, word_done);
        end
`endif
    endtask

    task automatic test_shift_left_sat();
        step(2'b11, 1'b0, 1'b0, 8'h01);
        e = sb.pop_front();
        checks++;
        if (q !== e.q || shift_cnt !== e.cnt) begin
            errors++;
            $display("FAIL load_01: q=%h cnt=%0d, expected q=%h cnt=%0d", q, shift_cnt, e.q, e.cnt);
        end
        for (int i = 0; i < 10; i++) begin
            step(2'b10, 1'b1, 1'b0, 8'h00);
            e = sb.pop_front();
            checks++;
            if (q !== e.q || qn !== ~e.q || shift_cnt !== e.cnt || word_done !== (e.cnt == 4'd8) ||
                so_r !== e.q[0] || so_l !== e.q[W-1]) begin
                errors++;
                $display("FAIL shl[%0d]: q=%h qn=%h cnt=%0d wd=%b so_r=%b so_l=%b, expected q=%h cnt=%0d",
                         i, q, qn, shift_cnt, word_done, so_r, so_l, e.q, e.cnt);
            end
            if (i >= 7) begin
                checks++;
                if (shift_cnt !== 4'd8 || word_done !== 1'b1) begin
                    errors++;
                    $display("FAIL shl_sat[%0d]: cnt=%0d wd=%b, expected cnt=8 wd=1", i, shift_cnt, word_done);
                end
            end
        end
`ifndef USR_ROTATE_EN
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL shl_final: q=%h, expected q=00", q);
        end
`endif
    endtask

    task automatic test_hold();
        step(2'b11, 1'b0, 1'b0, 8'h3C);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            step(2'b00, i[0], ~i[0], 8'hFF);
            e = sb.pop_front();
            checks++;
            if (q !== 8'h3C || q !== e.q || qn !== 8'hC3 || shift_cnt !== 4'd0 || word_done !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: q=%h qn=%h cnt=%0d wd=%b, expected q=3c qn=c3 cnt=0 wd=0",
                         i, q, qn, shift_cnt, word_done);
            end
        end
    endtask

    task automatic test_async_reset();
        step(2'b11, 1'b0, 1'b0, 8'h5A);
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            step(2'b01, 1'b0, 1'b0, 8'h00);
            e = sb.pop_front();
        end
        checks++;
        if (q !== e.q || shift_cnt !== 4'd3) begin
            errors++;
            $display("FAIL pre_reset: q=%h cnt=%0d, expected q=%h cnt=3", q, shift_cnt, e.q);
        end
        // Pulse reset between edges; results must change before any further clock edge.
        #1;
        res = 1'b0;
        #1;
        checks++;
        if (q !== 8'h00 || qn !== 8'hFF || shift_cnt !== 4'd0 || word_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: q=%h qn=%h cnt=%0d wd=%b, expected q=00 qn=ff cnt=0 wd=0",
                     q, qn, shift_cnt, word_done);
        end
        res   = 1'b1;
        m_q   = 8'h00;
        m_cnt = 4'd0;
        step(2'b11, 1'b0, 1'b0, 8'h81);
        e = sb.pop_front();
        checks++;
        if (q !== 8'h81 || q !== e.q || shift_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reload_81: q=%h cnt=%0d, expected q=81 cnt=0", q, shift_cnt);
        end
    endtask

`ifdef USR_ROTATE_EN
    task automatic test_rotate();
        step(2'b11, 1'b0, 1'b0, 8'h81);
        e = sb.pop_front();
        for (int i = 0; i < 8; i++) begin
            step(2'b01, 1'b0, 1'b0, 8'h00);
            e = sb.pop_front();
            checks++;
            if (q !== e.q || shift_cnt !== e.cnt || word_done !== (e.cnt == 4'd8)) begin
                errors++;
                $display("FAIL rot[%0d]: q=%h cnt=%0d wd=%b, expected q=%h cnt=%0d",
                         i, q, shift_cnt, word_done, e.q, e.cnt);
            end
            if (i < 2) begin
                checks++;
                if (q !== ((i == 0) ? 8'hC0 : 8'h60)) begin
                    errors++;
                    $display("FAIL rot_early[%0d]: q=%h, expected q=%h", i, q, (i == 0) ? 8'hC0 : 8'h60);
                end
            end
        end
        checks++;
        if (q !== 8'h81 || word_done !== 1'b1) begin
            errors++;
            $display("FAIL rot_final: q=%h wd=%b, expected q=81 wd=1", q, word_done);
        end
    endtask
`else
    task automatic test_mixed_count();
        step(2'b11, 1'b0, 1'b0, 8'h0F);
        e = sb.pop_front();
        for (int i = 0; i < 9; i++) begin
            step(i[0] ? 2'b10 : 2'b01, i[1], i[2], 8'h00);
            e = sb.pop_front();
            checks++;
            if (q !== e.q || shift_cnt !== e.cnt || word_done !== (e.cnt == 4'd8)) begin
                errors++;
                $display("FAIL mixed[%0d]: q=%h cnt=%0d wd=%b, expected q=%h cnt=%0d",
                         i, q, shift_cnt, word_done, e.q, e.cnt);
            end
        end
    endtask
`endif

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            logic [1:0] md;
            md = 2'($urandom_range(0, 3));
            // Keep loads rare so the counter regularly reaches saturation.
            if (md == 2'b11 && $urandom_range(0, 3) != 0) md = 2'b01;
            step(md, 1'($urandom), 1'($urandom), 8'($urandom));
            e = sb.pop_front();
            checks++;
            if (q !== e.q || qn !== ~e.q || shift_cnt !== e.cnt || word_done !== (e.cnt == 4'd8) ||
                so_r !== e.q[0] || so_l !== e.q[W-1]) begin
                errors++;
                $display("FAIL b2b[%0d]: q=%h qn=%h cnt=%0d wd=%b so_r=%b so_l=%b, expected q=%h cnt=%0d",
                         i, q, qn, shift_cnt, word_done, so_r, so_l, e.q, e.cnt);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_load_shift_right();
        test_shift_left_sat();
        test_hold();
        test_async_reset();
`ifdef USR_ROTATE_EN
        test_rotate();
`else
        test_mixed_count();
`endif
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
